psl_command_responder: RTL and testbench
========================================

Name: psl_command_responder

Overview:
- PSL-side counterpart to our CAPI work elements: accepts AFU commands, moves data through the AFU buffer interface, and returns tagged responses.
- Backed by a small cache-line memory, so work elements can run closed-loop in simulation and on the emulation fabric without a real PSL.
- Handles READ_CL_NA and WRITE_NA. Processes one command at a time, in order, from an internal command FIFO.

Parameters:
MEM_LINES, 16, number of 128-byte lines in the backing memory (power of 2, ≥2)
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
BR_LATENCY, 1, cycles from ha_brvalid to valid ah_brdata

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
ah_cvalid  input  1  command valid
ah_com  input  13  command code
ah_compar  input  1  command parity (odd)
ah_ctag  input  8  command tag
ah_ctagpar  input  1  tag parity (odd)
ah_cea  input  64  effective address
ah_ceapar  input  1  address parity (odd)
ah_csize  input  12  transfer size in bytes
ah_brdata  input  512  buffer read data from AFU
ha_brvalid  output  1  buffer read request
ha_brtag  output  8  buffer read tag
ha_brad  output  6  buffer read half-line address
ha_bwvalid  output  1  buffer write valid
ha_bwtag  output  8  buffer write tag
ha_bwad  output  6  buffer write half-line address
ha_bwdata  output  512  buffer write data
ha_bwpar  output  8  buffer write data parity, one odd bit per 64-bit word
ha_rvalid  output  1  response valid
ha_rtag  output  8  response tag
ha_rtagpar  output  1  response tag parity (odd)
ha_response  output  8  response code
ha_rcredits  output  9  credits returned with response
overflow  output  1  sticky: command dropped on full FIFO

Behaviour:
- Reset: all ha_* valids 0, all ha_* data/tag/address fields 0, overflow 0, FIFO empty, FSM IDLE. Memory contents are not reset.
- Reset mid-operation aborts the command in flight and flushes the FIFO. No response is issued for aborted or flushed commands.
- Command capture: ah_cvalid high at a posedge pushes {com, tag, cea, csize, parity bits} into the FIFO.
  - FIFO full: command dropped, overflow set until reset.
  - Push and pop in the same cycle when full: the pop happens first, so the push is accepted.
- Line index = ah_cea[7 +: log2(MEM_LINES)]. Address bits above that range nonzero → AERROR.
- Codes:
  - Commands: READ_CL_NA = 0x0A00, WRITE_NA = 0x0D00.
  - Responses: DONE = 0x00, AERROR = 0x01, FAILED = 0x08.
  - Any other ah_com → FAILED.
  - csize must be 128; otherwise FAILED.
- FSM: IDLE → DECODE → {RD_H0 → RD_H1 | WR_REQ0 → WR_REQ1 → WR_WAIT} → RESP → IDLE. Error paths go DECODE → RESP.
- IDLE pops the FIFO head when the FIFO is non-empty. Call the cycle the command is pushed into an empty FIFO with the FSM idle cycle C.
- READ_CL_NA:
  - C+2: ha_bwvalid=1, bwad=0, bwdata = mem[line][511:0].
  - C+3: bwad=1, bwdata = mem[line][1023:512].
  - C+4: ha_rvalid, DONE.
- WRITE_NA:
  - C+2: ha_brvalid, brad=0.
  - C+3: ha_brvalid, brad=1.
  - ah_brdata is sampled at C+2+BR_LATENCY (low half) and C+3+BR_LATENCY (high half).
  - Memory is written only once both halves are captured.
  - C+4+BR_LATENCY: ha_rvalid, DONE.
- Error responses: ha_rvalid at C+2. No buffer traffic and no memory change.
- All valids are single-cycle pulses. Tags echo ah_ctag.
- ha_rcredits = 1 on every response, 0 otherwise.
- Back-to-back commands: the next pop occurs in the cycle after RESP, so there are no idle bubbles beyond that cycle.
- All output parity bits are computed combinationally from their registered fields.

Optional Feature:
PSL_PARITY_CHECK_EN
- Defined: in DECODE, any mismatch of ah_compar/ah_ctagpar/ah_ceapar against odd parity of the captured field → FAILED response at C+2. No buffer traffic, no memory write. Parity checking has priority over all other decode checks.
- Undefined: parity inputs are ignored; outputs still carry generated parity.

Test Plan:
- READ_CL_NA tag 0x05, cea 0x180 (line 3), mem[3] preloaded → bwvalid bwad 0 at C+2 and bwad 1 at C+3 with matching halves; rvalid at C+4 with rtag 0x05, response 0x00, rcredits 1.
- WRITE_NA tag 0x11, cea 0x100, BR_LATENCY 1, AFU drives 0xAA.. / 0x55.. halves → brvalid at C+2 and C+3; rvalid at C+5 with DONE; a follow-up read of line 2 returns the written data.
- Command 0x1234 tag 0x07 → FAILED 0x08 at C+2, no brvalid/bwvalid. cea bit 40 set → AERROR 0x01.
- 5 commands pushed on consecutive cycles, FIFO_DEPTH 4, FSM busy → 5th dropped, overflow=1; exactly 4 responses, in push order.
- Reset asserted at C+3 of a write → no response, memory line unchanged, all outputs 0 at the next cycle.
- With PSL_PARITY_CHECK_EN, corrupted ah_compar on a READ_CL_NA → FAILED at C+2, no bwvalid; without the macro, the same stimulus → DONE.

Source files
------------

// File: rtl/psl_command_responder.sv
// PSL-side responder for READ_CL_NA / WRITE_NA backed by a small cache-line memory.
// Define PSL_PARITY_CHECK_EN to fail commands whose com/tag/ea parity inputs are wrong.
module psl_command_responder #(
    parameter int MEM_LINES  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BR_LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ah_cvalid,
    input  logic [12:0]  ah_com,
    input  logic         ah_compar,
    input  logic [7:0]   ah_ctag,
    input  logic         ah_ctagpar,
    input  logic [63:0]  ah_cea,
    input  logic         ah_ceapar,
    input  logic [11:0]  ah_csize,
    input  logic [511:0] ah_brdata,
    output logic         ha_brvalid,
    output logic [7:0]   ha_brtag,
    output logic [5:0]   ha_brad,
    output logic         ha_bwvalid,
    output logic [7:0]   ha_bwtag,
    output logic [5:0]   ha_bwad,
    output logic [511:0] ha_bwdata,
    output logic [7:0]   ha_bwpar,
    output logic         ha_rvalid,
    output logic [7:0]   ha_rtag,
    output logic         ha_rtagpar,
    output logic [7:0]   ha_response,
    output logic [8:0]   ha_rcredits,
    output logic         overflow
);
    localparam int LW = $clog2(MEM_LINES);
    localparam int FW = $clog2(FIFO_DEPTH);

    localparam logic [12:0] CMD_READ_CL_NA = 13'h0A00;
    localparam logic [12:0] CMD_WRITE_NA   = 13'h0D00;
    localparam logic [7:0]  RESP_DONE      = 8'h00;
    localparam logic [7:0]  RESP_AERROR    = 8'h01;
    localparam logic [7:0]  RESP_FAILED    = 8'h08;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_RD_H0, S_RD_H1, S_WR_REQ0, S_WR_REQ1, S_WR_WAIT, S_RESP
    } state_t;

    typedef struct packed {
        logic [12:0] com;
        logic [7:0]  tag;
        logic [56:0] cea_hi;   // ah_cea[63:7]; the byte offset inside a line is ignored
        logic [11:0] csize;
        logic        par_err;
    } cmd_t;

    state_t              r_state, w_next_state;
    cmd_t                r_fifo [FIFO_DEPTH];
    cmd_t                r_cmd;
    logic [FW:0]         r_wr_ptr, r_rd_ptr;
    logic                r_overflow;
    logic [1023:0]       r_mem [MEM_LINES];
    logic [511:0]        r_lo;
    logic [BR_LATENCY-1:0] r_br_vld, r_br_hi;

    logic                w_empty, w_full, w_pop, w_push, w_par_err;
    logic                w_lo_valid, w_hi_valid;
    logic [LW-1:0]       w_line;
    logic [7:0]          w_resp;

`ifdef PSL_PARITY_CHECK_EN
    // Evaluated at capture and carried with the entry; acted on in DECODE.
    assign w_par_err = (ah_compar != ~^ah_com) || (ah_ctagpar != ~^ah_ctag) ||
                       (ah_ceapar != ~^ah_cea);
`else
    logic w_unused;
    assign w_unused  = ^{ah_compar, ah_ctagpar, ah_ceapar, ah_cea[6:0]};
    assign w_par_err = 1'b0;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FW] != r_rd_ptr[FW]) && (r_wr_ptr[FW-1:0] == r_rd_ptr[FW-1:0]);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_push  = ah_cvalid && (!w_full || w_pop);
    assign overflow = r_overflow;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (ah_cvalid && !w_push) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; pointers and FSM state decide what is valid.
    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr[FW-1:0]] <= '{ah_com, ah_ctag, ah_cea[63:7], ah_csize, w_par_err};
        if (w_pop)  r_cmd <= r_fifo[r_rd_ptr[FW-1:0]];
    end

    assign w_line = r_cmd.cea_hi[LW-1:0];

    always_comb begin
        w_resp = RESP_DONE;
        if (r_cmd.par_err)
            w_resp = RESP_FAILED;
        else if (((r_cmd.com != CMD_READ_CL_NA) && (r_cmd.com != CMD_WRITE_NA)) ||
                 (r_cmd.csize != 12'd128))
            w_resp = RESP_FAILED;
        else if (r_cmd.cea_hi[56:LW] != '0)
            w_resp = RESP_AERROR;
    end

    // Delay line tracking which buffer-read half the AFU is presenting this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_br_vld <= '0;
            r_br_hi  <= '0;
        end else begin
            r_br_vld[0] <= ha_brvalid;
            r_br_hi[0]  <= ha_brad[0];
            for (int i = 1; i < BR_LATENCY; i++) begin
                r_br_vld[i] <= r_br_vld[i-1];
                r_br_hi[i]  <= r_br_hi[i-1];
            end
        end
    end

    assign w_lo_valid = r_br_vld[BR_LATENCY-1] && !r_br_hi[BR_LATENCY-1];
    assign w_hi_valid = r_br_vld[BR_LATENCY-1] &&  r_br_hi[BR_LATENCY-1];

    always_ff @(posedge clock) begin
        if (w_lo_valid) r_lo <= ah_brdata;
        if (!reset && w_hi_valid) r_mem[w_line] <= {ah_brdata, r_lo};
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (!w_empty) w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_resp != RESP_DONE)              w_next_state = S_RESP;
                else if (r_cmd.com == CMD_READ_CL_NA) w_next_state = S_RD_H0;
                else                                  w_next_state = S_WR_REQ0;
            end
            S_RD_H0:   w_next_state = S_RD_H1;
            S_RD_H1:   w_next_state = S_RESP;
            S_WR_REQ0: w_next_state = S_WR_REQ1;
            S_WR_REQ1: w_next_state = S_WR_WAIT;
            S_WR_WAIT: if (w_hi_valid) w_next_state = S_RESP;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ha_brvalid  = 1'b0;
        ha_brtag    = '0;
        ha_brad     = '0;
        ha_bwvalid  = 1'b0;
        ha_bwtag    = '0;
        ha_bwad     = '0;
        ha_bwdata   = '0;
        ha_rvalid   = 1'b0;
        ha_rtag     = '0;
        ha_response = '0;
        ha_rcredits = '0;
        case (r_state)
            S_RD_H0: begin
                ha_bwvalid = 1'b1;
                ha_bwtag   = r_cmd.tag;
                ha_bwdata  = r_mem[w_line][511:0];
            end
            S_RD_H1: begin
                ha_bwvalid = 1'b1;
                ha_bwtag   = r_cmd.tag;
                ha_bwad    = 6'd1;
                ha_bwdata  = r_mem[w_line][1023:512];
            end
            S_WR_REQ0: begin
                ha_brvalid = 1'b1;
                ha_brtag   = r_cmd.tag;
            end
            S_WR_REQ1: begin
                ha_brvalid = 1'b1;
                ha_brtag   = r_cmd.tag;
                ha_brad    = 6'd1;
            end
            S_RESP: begin
                ha_rvalid   = 1'b1;
                ha_rtag     = r_cmd.tag;
                ha_response = w_resp;
                ha_rcredits = 9'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 8; i++) ha_bwpar[i] = ~^ha_bwdata[64*i +: 64];
    end

    assign ha_rtagpar = ~^ha_rtag;

endmodule

// File: tb/tb_psl_command_responder.sv
// Self-checking bench for psl_command_responder: random and directed commands against a line-level model.
module tb_psl_command_responder;
    localparam int MEM_LINES  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int BRL        = 1;
    localparam int LW         = $clog2(MEM_LINES);

    localparam logic [12:0] CMD_READ  = 13'h0A00;
    localparam logic [12:0] CMD_WRITE = 13'h0D00;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ah_cvalid = 1'b0;
    logic [12:0]  ah_com = '0;
    logic         ah_compar = 1'b0;
    logic [7:0]   ah_ctag = '0;
    logic         ah_ctagpar = 1'b0;
    logic [63:0]  ah_cea = '0;
    logic         ah_ceapar = 1'b0;
    logic [11:0]  ah_csize = '0;
    logic [511:0] ah_brdata = '0;
    logic         ha_brvalid, ha_bwvalid, ha_rvalid, ha_rtagpar, overflow;
    logic [7:0]   ha_brtag, ha_bwtag, ha_rtag, ha_response, ha_bwpar;
    logic [5:0]   ha_brad, ha_bwad;
    logic [511:0] ha_bwdata;
    logic [8:0]   ha_rcredits;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1023:0] m_mem [MEM_LINES];
    logic [1023:0] afu_buf = '0;
    bit            afu_vld [BRL];
    bit            afu_hi  [BRL];
    logic [15:0]   rsp_q [$];
    logic [15:0]   exp_q [$];

    always #5 clock = ~clock;

    psl_command_responder #(.MEM_LINES(MEM_LINES), .FIFO_DEPTH(FIFO_DEPTH), .BR_LATENCY(BRL)) dut (
        .clock(clock), .reset(reset),
        .ah_cvalid(ah_cvalid), .ah_com(ah_com), .ah_compar(ah_compar),
        .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar), .ah_cea(ah_cea), .ah_ceapar(ah_ceapar),
        .ah_csize(ah_csize), .ah_brdata(ah_brdata),
        .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brad(ha_brad),
        .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwad(ha_bwad),
        .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar),
        .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_rtagpar(ha_rtagpar),
        .ha_response(ha_response), .ha_rcredits(ha_rcredits), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // AFU side: returns the requested half of afu_buf BRL cycles after each buffer read request.
    always @(posedge clock) begin
        bit out_vld, out_hi;
        #1;
        out_vld = afu_vld[BRL-1];
        out_hi  = afu_hi[BRL-1];
        for (int i = BRL - 1; i > 0; i--) begin
            afu_vld[i] = afu_vld[i-1];
            afu_hi[i]  = afu_hi[i-1];
        end
        afu_vld[0] = ha_brvalid;
        afu_hi[0]  = ha_brad[0];
        if (out_vld) ah_brdata = out_hi ? afu_buf[1023:512] : afu_buf[511:0];
        else         ah_brdata = {$urandom, {15{32'h0}}} ^ {16{$urandom}};
    end

    always @(posedge clock) begin
        #1;
        if (ha_rvalid) rsp_q.push_back({ha_rtag, ha_response});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] exp_resp(input logic [12:0] com, input logic [63:0] cea,
                                            input logic [11:0] csize, input bit bad_par);
`ifdef PSL_PARITY_CHECK_EN
        if (bad_par) return 8'h08;
`endif
        if (!(com == CMD_READ || com == CMD_WRITE) || csize != 12'd128) return 8'h08;
        if ((cea >> (7 + LW)) != 64'd0) return 8'h01;
        return 8'h00;
    endfunction

    function automatic logic [7:0] bw_par(input logic [511:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ~^d[64*i +: 64];
        return p;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_cmd(input logic [12:0] com, input logic [7:0] tag, input logic [63:0] cea,
                            input logic [11:0] csize, input bit bad_par);
        ah_cvalid  = 1'b1;
        ah_com     = com;
        ah_compar  = (~^com) ^ bad_par;
        ah_ctag    = tag;
        ah_ctagpar = ~^tag;
        ah_cea     = cea;
        ah_ceapar  = ~^cea;
        ah_csize   = csize;
        @(posedge clock); #1;
        ah_cvalid  = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, " valids"}, 512'({ha_brvalid, ha_bwvalid, ha_rvalid, overflow}), 512'(0));
        check({name, " fields"}, 512'({ha_brtag, ha_brad, ha_bwtag, ha_bwad, ha_rtag,
                                       ha_response, ha_rcredits}), 512'(0));
        check({name, " bwdata"}, ha_bwdata, 512'(0));
    endtask

    // Issue one command into an idle responder and check every cycle up to two past its response.
    task automatic do_cmd(input string name, input logic [12:0] com, input logic [7:0] tag,
                          input logic [63:0] cea, input logic [11:0] csize, input bit bad_par,
                          input logic [1023:0] wdata);
        logic [7:0]   rsp;
        int           line, t_resp;
        bit           is_rd, is_wr, exp_bw, exp_br, exp_rv;
        logic [511:0] half;
        rsp    = exp_resp(com, cea, csize, bad_par);
        line   = int'(cea[7 +: LW]);
        is_rd  = (rsp == 8'h00) && (com == CMD_READ);
        is_wr  = (rsp == 8'h00) && (com == CMD_WRITE);
        t_resp = (rsp != 8'h00) ? 2 : (is_rd ? 4 : 4 + BRL);
        afu_buf = wdata;
        push_cmd(com, tag, cea, csize, bad_par);
        for (int k = 1; k <= t_resp + 2; k++) begin
            @(posedge clock); #1;
            exp_bw = is_rd && (k == 2 || k == 3);
            exp_br = is_wr && (k == 2 || k == 3);
            exp_rv = (k == t_resp);
            check($sformatf("%s c%0d valids", name, k),
                  512'({ha_bwvalid, ha_brvalid, ha_rvalid, ha_rcredits}),
                  512'({exp_bw, exp_br, exp_rv, exp_rv ? 9'd1 : 9'd0}));
            if (exp_bw) begin
                half = (k == 2) ? m_mem[line][511:0] : m_mem[line][1023:512];
                check($sformatf("%s c%0d bwtag/ad", name, k), 512'({ha_bwtag, ha_bwad}),
                      512'({tag, 6'(k - 2)}));
                check($sformatf("%s c%0d bwdata", name, k), ha_bwdata, half);
                check($sformatf("%s c%0d bwpar", name, k), 512'(ha_bwpar), 512'(bw_par(half)));
            end
            if (exp_br)
                check($sformatf("%s c%0d brtag/ad", name, k), 512'({ha_brtag, ha_brad}),
                      512'({tag, 6'(k - 2)}));
            if (exp_rv)
                check($sformatf("%s c%0d resp", name, k),
                      512'({ha_rtag, ha_rtagpar, ha_response}), 512'({tag, ~^tag, rsp}));
        end
        if (is_wr) m_mem[line] = wdata;
    endtask

    initial begin
        logic [12:0] com;
        logic [63:0] cea;
        logic [11:0] csize;
        bit          bad;
        int          r;

        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < MEM_LINES; i++)
            do_cmd($sformatf("preload%0d", i), CMD_WRITE, 8'(8'h40 + i), 64'(i) << 7, 12'd128, 1'b0, rand1024());

        do_cmd("read_l3", CMD_READ, 8'h05, 64'h180, 12'd128, 1'b0, '0);
        do_cmd("write_l2", CMD_WRITE, 8'h11, 64'h100, 12'd128, 1'b0, {{64{8'h55}}, {64{8'hAA}}});
        do_cmd("readback_l2", CMD_READ, 8'h12, 64'h100, 12'd128, 1'b0, '0);
        do_cmd("bad_com", 13'h1234, 8'h07, 64'h080, 12'd128, 1'b0, '0);
        do_cmd("aerror", CMD_READ, 8'h08, (64'd1 << 40) | 64'h080, 12'd128, 1'b0, '0);
        do_cmd("bad_size", CMD_WRITE, 8'h09, 64'h200, 12'd64, 1'b0, rand1024());
        do_cmd("bad_par", CMD_READ, 8'h0A, 64'h280, 12'd128, 1'b1, '0);
        do_cmd("top_line", CMD_READ, 8'h0B, 64'(MEM_LINES - 1) << 7 | 64'h7F, 12'd128, 1'b0, '0);

        for (int n = 0; n < 40; n++) begin
            r     = int'($urandom_range(0, 9));
            com   = (r < 4) ? CMD_READ : (r < 8) ? CMD_WRITE : (r == 8) ? 13'($urandom) : CMD_READ;
            csize = (r == 9) ? 12'($urandom_range(0, 4095)) : 12'd128;
            cea   = (64'($urandom_range(0, MEM_LINES - 1)) << 7) | 64'($urandom_range(0, 127));
            if (r < 8 && $urandom_range(0, 7) == 0) cea[$urandom_range(63, 7 + LW)] = 1'b1;
            bad   = ($urandom_range(0, 7) == 0);
            do_cmd($sformatf("rand%0d", n), com, 8'($urandom), cea, csize, bad, rand1024());
        end

        // Seven back-to-back pushes behind a busy FSM: the sixth hits a full FIFO and is dropped,
        // the seventh coincides with a pop and is accepted.
        rsp_q.delete();
        exp_q.delete();
        check("ovf_clear", 512'(overflow), 512'(0));
        for (int i = 0; i < 7; i++) begin
            com = (i == 3) ? 13'h1234 : CMD_READ;
            cea = 64'(i) << 7;
            push_cmd(com, 8'(8'h20 + i), cea, 12'd128, 1'b0);
            if (i != 5) exp_q.push_back({8'(8'h20 + i), exp_resp(com, cea, 12'd128, 1'b0)});
        end
        check("ovf_set", 512'(overflow), 512'(1));
        repeat (80) @(posedge clock);
        #2;
        check("fifo_rsp_count", 512'(rsp_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("fifo_rsp%0d", i), 512'((i < rsp_q.size()) ? rsp_q[i] : 16'hFFFF),
                  512'(exp_q[i]));

        // Reset during the second buffer-read request of a write aborts it silently.
        rsp_q.delete();
        afu_buf = rand1024();
        push_cmd(CMD_WRITE, 8'h33, 64'(5) << 7, 12'd128, 1'b0);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        check_zero("rst_mid");
        reset = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        check("rst_no_resp", 512'(rsp_q.size()), 512'(0));
        check("rst_ovf", 512'(overflow), 512'(0));
        do_cmd("rst_readback", CMD_READ, 8'h34, 64'(5) << 7, 12'd128, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
